// File: rtl/vcxo_pll_pkg.sv
// Shared types and default constants for the VCXO frequency-lock loop.
// The defaults describe a 10 MHz-class reference gating a 100 MHz-class VCXO.
package vcxo_pll_pkg;

  typedef enum logic [1:0] {
    ARM    = 2'd0,
    GATE   = 2'd1,
    CALC   = 2'd2,
    UPDATE = 2'd3
  } pll_state_t;

  localparam int CNT_W_DEF         = 32;
  localparam int REF_TICKS_DEF     = 1228800;
  localparam int NOMINAL_COUNT_DEF = 12288000;
  localparam int DAC_W_DEF         = 16;
  localparam int DAC_MIN_DEF       = 1;
  localparam int DAC_MAX_DEF       = 40000;
  localparam int DAC_INIT_DEF      = 20000;
  localparam int DEADBAND_DEF      = 10;
  localparam int KP_SHIFT_DEF      = 0;
  localparam int LOCK_THRESH_DEF   = 2;
  localparam int LOCK_COUNT_DEF    = 4;
  localparam int REF_TIMEOUT_DEF   = 1024;

endpackage

// File: rtl/vcxo_sd_modulator.sv
// First-order sigma-delta: turns the tuning word into a pump bitstream whose
// long-run duty is dac / modulus.
module vcxo_sd_modulator #(
  parameter int DAC_W = 16
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [DAC_W-1:0] dac,
  input  logic [DAC_W-1:0] modulus,
  output logic             pump
);

  logic [DAC_W:0] acc_reg;
  logic [DAC_W:0] sum;

  // acc stays below modulus, so one spare bit holds the sum
  assign sum = acc_reg + {1'b0, dac};

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      acc_reg <= '0;
      pump    <= 1'b0;
    end else if (sum >= {1'b0, modulus}) begin
      acc_reg <= sum - {1'b0, modulus};
      pump    <= 1'b1;
    end else begin
      acc_reg <= sum;
      pump    <= 1'b0;
    end
  end

endmodule

// File: rtl/vcxo_pll_controller.sv
// Frequency-lock loop: counts VCXO cycles over a reference-timed gate, turns the
// count error into a clamped DAC correction and tracks lock / reference loss.
module vcxo_pll_controller
  import vcxo_pll_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int REF_TICKS     = REF_TICKS_DEF,
  parameter int NOMINAL_COUNT = NOMINAL_COUNT_DEF,
  parameter int DAC_W         = DAC_W_DEF,
  parameter int DAC_MIN       = DAC_MIN_DEF,
  parameter int DAC_MAX       = DAC_MAX_DEF,
  parameter int DAC_INIT      = DAC_INIT_DEF,
  parameter int DEADBAND      = DEADBAND_DEF,
  parameter int KP_SHIFT      = KP_SHIFT_DEF,
  parameter int LOCK_THRESH   = LOCK_THRESH_DEF,
  parameter int LOCK_COUNT    = LOCK_COUNT_DEF,
  parameter int REF_TIMEOUT   = REF_TIMEOUT_DEF
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    tcxo_in,
  input  logic                    tx_in,
  input  logic signed [15:0]      correction_in,
  output logic signed [CNT_W-1:0] freq_error,
  output logic                    err_valid,
  output logic [DAC_W-1:0]        dac_out,
  output logic                    pump,
  output logic                    locked,
  output logic                    ref_lost
);

  localparam int EXT_W  = CNT_W + 1;
  localparam int EDGE_W = $clog2(REF_TICKS + 1);
  localparam int TO_W   = $clog2(REF_TIMEOUT + 1);
  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);

  pll_state_t state_reg, state_next;

  logic [2:0]              sync_reg;      // [1:0] synchroniser, [2] edge history
  logic [CNT_W-1:0]        clk_cnt_reg;
  logic [CNT_W-1:0]        count_reg;
  logic [EDGE_W-1:0]       edge_cnt_reg;
  logic [TO_W-1:0]         to_cnt_reg;
  logic [RUN_W-1:0]        run_cnt_reg;
  logic signed [CNT_W-1:0] err_reg;
  logic [DAC_W-1:0]        dac_rx_reg, dac_tx_reg;
  logic                    tx_prev_reg, tx_seeded_reg;

  logic ref_edge, gate_close, tx_change, timeout_hit, abort, clk_full;
  logic signed [CNT_W-1:0] corr_ext, err_calc;
  logic signed [EXT_W-1:0] err_ext, mag, dac_ext, new_val;
  logic [DAC_W-1:0]        dac_new;

  assign ref_edge    = sync_reg[1] & ~sync_reg[2];
  assign gate_close  = (state_reg != ARM) && ref_edge && (edge_cnt_reg == EDGE_W'(REF_TICKS - 1));
  assign tx_change   = tx_in != tx_prev_reg;
  assign timeout_hit = !ref_edge && (to_cnt_reg == TO_W'(REF_TIMEOUT - 1));
  assign abort       = tx_change || timeout_hit;
  assign clk_full    = &clk_cnt_reg;

  // Until TX has been seeded, the RX word is the one actually in use.
  assign dac_out = (tx_in && tx_seeded_reg) ? dac_tx_reg : dac_rx_reg;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_reg <= ARM;
      sync_reg  <= '0;
    end else begin
      state_reg <= state_next;
      sync_reg  <= {sync_reg[1:0], tcxo_in};
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = ARM;
    end else begin
      case (state_reg)
        ARM:     if (ref_edge) state_next = GATE;
        GATE:    if (gate_close) state_next = CALC;
        CALC:    state_next = UPDATE;
        UPDATE:  state_next = gate_close ? CALC : GATE;
        default: state_next = ARM;
      endcase
    end
  end

  // The closing edge also opens the next gate, so counting never pauses.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      clk_cnt_reg  <= '0;
      edge_cnt_reg <= '0;
      count_reg    <= '0;
    end else if (state_reg == ARM) begin
      if (ref_edge) begin
        clk_cnt_reg  <= '0;
        edge_cnt_reg <= '0;
      end
    end else if (gate_close) begin
      count_reg    <= clk_full ? clk_cnt_reg : clk_cnt_reg + CNT_W'(1);
      clk_cnt_reg  <= '0;
      edge_cnt_reg <= '0;
    end else begin
      if (!clk_full) clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
      if (ref_edge) edge_cnt_reg <= edge_cnt_reg + EDGE_W'(1);
    end
  end

  assign corr_ext = {{(CNT_W - 16){correction_in[15]}}, correction_in};
  assign err_calc = $signed(count_reg) - $signed(CNT_W'(NOMINAL_COUNT)) + corr_ext;

  // One spare bit keeps dac - err and |err| free of overflow before clamping.
  always_comb begin
    err_ext = $signed({err_reg[CNT_W-1], err_reg});
    mag     = err_ext[EXT_W-1] ? -err_ext : err_ext;
    dac_ext = $signed({{(EXT_W - DAC_W){1'b0}}, dac_out});
    new_val = dac_ext;
    if (mag > EXT_W'(DEADBAND))
      new_val = dac_ext - (err_ext >>> KP_SHIFT);
    else if (err_ext[EXT_W-1])
      new_val = dac_ext + EXT_W'(1);
    else if (err_ext != '0)
      new_val = dac_ext - EXT_W'(1);
    if (new_val < EXT_W'(DAC_MIN))
      dac_new = DAC_W'(DAC_MIN);
    else if (new_val > EXT_W'(DAC_MAX))
      dac_new = DAC_W'(DAC_MAX);
    else
      dac_new = new_val[DAC_W-1:0];
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      freq_error    <= '0;
      err_reg       <= '0;
      err_valid     <= 1'b0;
      locked        <= 1'b0;
      ref_lost      <= 1'b0;
      run_cnt_reg   <= '0;
      to_cnt_reg    <= '0;
      dac_rx_reg    <= DAC_W'(DAC_INIT);
      dac_tx_reg    <= DAC_W'(DAC_INIT);
      tx_prev_reg   <= 1'b0;
      tx_seeded_reg <= 1'b0;
    end else begin
      err_valid   <= 1'b0;
      tx_prev_reg <= tx_in;
      if (ref_edge)
        to_cnt_reg <= '0;
      else if (to_cnt_reg != TO_W'(REF_TIMEOUT))
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
      if (ref_edge)
        ref_lost <= 1'b0;
      else if (timeout_hit)
        ref_lost <= 1'b1;

      if (tx_change) begin
        locked      <= 1'b0;
        run_cnt_reg <= '0;
        if (tx_in && !tx_seeded_reg) begin
          dac_tx_reg    <= dac_rx_reg;
          tx_seeded_reg <= 1'b1;
        end
      end else if (timeout_hit) begin
        locked      <= 1'b0;
        run_cnt_reg <= '0;
      end else if (state_reg == CALC) begin
        freq_error <= err_calc;
        err_reg    <= err_calc;
        err_valid  <= 1'b1;
      end else if (state_reg == UPDATE) begin
        if (tx_in) dac_tx_reg <= dac_new;
        else       dac_rx_reg <= dac_new;
        if (mag <= EXT_W'(LOCK_THRESH)) begin
          if (run_cnt_reg == RUN_W'(LOCK_COUNT - 1)) locked <= 1'b1;
          else run_cnt_reg <= run_cnt_reg + RUN_W'(1);
        end else begin
          locked      <= 1'b0;
          run_cnt_reg <= '0;
        end
      end
    end
  end

  vcxo_sd_modulator #(
    .DAC_W (DAC_W)
  ) u_modulator (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .dac      (dac_out),
    .modulus  (DAC_W'(DAC_MAX)),
    .pump     (pump)
  );

endmodule

// File: tb/tb_vcxo_pll_controller.sv
// Directed bench for the VCXO loop with a 10-tick gate and nominal count of 100;
// the reference is built from a 10-entry period table (in clk cycles).
module tb_vcxo_pll_controller;

  logic               clk_in = 1'b0;
  logic               reset_in;
  logic               tcxo_in;
  logic               tx_in;
  logic signed [15:0] correction_in;
  logic signed [31:0] freq_error;
  logic               err_valid;
  logic [15:0]        dac_out;
  logic               pump;
  logic               locked;
  logic               ref_lost;

  int n_checks = 0;
  int n_fail   = 0;
  int per[10];
  logic tcxo_en;
  int tcxo_p;
  int tcxo_idx = 0;
  int pump_ones;
  logic seen;

  int corr_tab[10] = '{-19990, -50, 20000, 19995, 50, -9999, 11, 10, -12, 0};
  int dac_tab[10]  = '{39990, 40000, 20000, 5, 1, 10000, 9989, 9988, 10000, 10000};

  always #5 clk_in = ~clk_in;

  vcxo_pll_controller #(
    .REF_TICKS     (10),
    .NOMINAL_COUNT (100)
  ) dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .tcxo_in       (tcxo_in),
    .tx_in         (tx_in),
    .correction_in (correction_in),
    .freq_error    (freq_error),
    .err_valid     (err_valid),
    .dac_out       (dac_out),
    .pump          (pump),
    .locked        (locked),
    .ref_lost      (ref_lost)
  );

  initial begin
    tcxo_in = 1'b0;
    forever begin
      if (tcxo_en === 1'b1) begin
        tcxo_p   = per[tcxo_idx];
        tcxo_idx = (tcxo_idx + 1) % 10;
        repeat (tcxo_p - tcxo_p / 2) @(negedge clk_in);
        tcxo_in = 1'b1;
        repeat (tcxo_p / 2) @(negedge clk_in);
        tcxo_in = 1'b0;
      end else begin
        @(negedge clk_in);
      end
    end
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_period(input int p);
    for (int i = 0; i < 10; i++) per[i] = p;
  endtask

  // Holds reset long enough for any old-table period to finish, then releases
  // while the reference is low so the first gate opens on a true edge.
  task automatic restart();
    reset_in = 1'b1;
    repeat (30) @(negedge clk_in);
    check("rst freq_error", freq_error, 0);
    check("rst err_valid", err_valid, 0);
    check("rst dac_out", dac_out, 20000);
    check("rst locked", locked, 0);
    check("rst ref_lost", ref_lost, 0);
    check("rst pump", pump, 0);
    @(negedge tcxo_in);
    reset_in = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk_in);
      k++;
    end while (err_valid !== 1'b1 && k < 400);
    check(tag, err_valid, 1);
    $display("gate %s: freq_error=%0d dac_out=%0d locked=%0b", tag, freq_error, dac_out, locked);
  endtask

  initial begin
    reset_in      = 1'b1;
    tx_in         = 1'b0;
    correction_in = '0;
    set_period(10);
    tcxo_en = 1'b1;
    restart();

    // exact ratio: zero error, word unchanged, lock after the fourth gate
    for (int g = 1; g <= 4; g++) begin
      wait_valid("exact");
      check("exact freq_error", freq_error, 0);
      @(negedge clk_in);
      check("exact dac_out", dac_out, 20000);
      if (g == 3) check("exact not yet locked", locked, 0);
      if (g == 4) check("exact locked", locked, 1);
    end

    // slow reference: count 130 -> coarse step of 30
    set_period(13);
    restart();
    wait_valid("slow");
    check("slow freq_error", freq_error, 30);
    check("slow dac before writeback", dac_out, 20000);
    @(negedge clk_in);
    check("slow dac after writeback", dac_out, 19970);
    check("slow locked", locked, 0);

    // count 104 from a period pattern summing to 104 over any 10 periods
    per = '{11, 10, 11, 10, 11, 10, 11, 10, 10, 10};
    restart();
    for (int g = 1; g <= 3; g++) begin
      wait_valid("fine");
      check("fine freq_error", freq_error, 4);
      @(negedge clk_in);
      check("fine dac_out", dac_out, 20000 - g);
      check("fine locked", locked, 0);
    end

    // correction-driven walk through clamps and the deadband edges
    set_period(10);
    correction_in = 16'(corr_tab[0]);
    restart();
    for (int i = 0; i < 10; i++) begin
      correction_in = 16'(corr_tab[i]);
      wait_valid("corr");
      check("corr freq_error", freq_error, corr_tab[i]);
      @(negedge clk_in);
      check("corr dac_out", dac_out, dac_tab[i]);
    end

    pump_ones = 0;
    repeat (40000) begin
      @(negedge clk_in);
      if (pump === 1'b1) pump_ones++;
    end
    check("pump ones in 40000", pump_ones, 10000);
    check("locked before lock test", locked, 1);

    correction_in = 16'sd3;
    wait_valid("thr3");
    @(negedge clk_in);
    check("err3 dac_out", dac_out, 9999);
    check("err3 unlocks", locked, 0);
    correction_in = 16'sd2;
    for (int g = 1; g <= 4; g++) begin
      wait_valid("thr2");
      @(negedge clk_in);
      check("err2 dac_out", dac_out, 9999 - g);
      if (g == 3) check("err2 not yet locked", locked, 0);
      if (g == 4) check("err2 locked", locked, 1);
    end

    // TX switch mid-gate: abort, seed TX from RX, no writeback
    correction_in = 16'sd100;
    repeat (50) @(negedge clk_in);
    tx_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check("tx locked cleared", locked, 0);
    check("tx seeded dac_out", dac_out, 9995);
    seen = 1'b0;
    repeat (95) begin
      @(negedge clk_in);
      if (err_valid === 1'b1) seen = 1'b1;
    end
    check("tx aborted gate no result", seen, 0);
    check("tx dac held", dac_out, 9995);
    wait_valid("tx");
    check("tx freq_error", freq_error, 100);
    @(negedge clk_in);
    check("tx dac updated", dac_out, 9895);
    correction_in = '0;
    tx_in = 1'b0;
    repeat (2) @(negedge clk_in);
    check("rx word untouched", dac_out, 9995);
    check("rx locked cleared", locked, 0);
    for (int g = 1; g <= 4; g++) begin
      wait_valid("rx");
      check("rx freq_error", freq_error, 0);
    end
    @(negedge clk_in);
    check("rx relocked", locked, 1);

    // reference loss and recovery
    tcxo_en = 1'b0;
    repeat (1000) @(negedge clk_in);
    check("ref_lost not yet", ref_lost, 0);
    repeat (60) @(negedge clk_in);
    check("ref_lost set", ref_lost, 1);
    check("ref_lost unlocks", locked, 0);
    check("ref_lost dac held", dac_out, 9995);
    tcxo_en = 1'b1;
    repeat (30) @(negedge clk_in);
    check("ref_lost cleared", ref_lost, 0);
    wait_valid("recover");
    check("recover freq_error", freq_error, 0);
    @(negedge clk_in);
    check("recover dac_out", dac_out, 9995);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
